// File: rtl/trap_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// common -- shared definitions for the machine-mode trap sequencer.
//
// Contents:
//   state_e        sequencer states (trap path T_*, mret path R_*)
//   CSR_*          CSR addresses touched by the sequencer
//   MSTATUS_*      mstatus bit positions (MIE, MPIE, MPP)
//   PRIV_*         privilege encodings
//   vector_target  trap-vector target from mtvec and mcause
// ---------------------------------------------------------------------------
package common;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      T_EPC    = 3'd1,
      T_CAUSE  = 3'd2,
      T_TVAL   = 3'd3,
      T_STATUS = 3'd4,
      T_REDIR  = 3'd5,
      R_STATUS = 3'd6,
      R_REDIR  = 3'd7
   } state_e;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [11:0] CSR_MTVAL   = 12'h343;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [1:0] PRIV_M = 2'd3;
   localparam logic [1:0] PRIV_U = 2'd0;

   localparam logic [63:0] CAUSE_ILLEGAL_INSN = 64'd2;

   // Direct mode (or any synchronous exception) jumps to the aligned base.
   // Vectored mode (mtvec[1:0] == 1) offsets interrupts by 4 * cause code.
   function automatic logic [63:0] vector_target(input logic [63:0] mtvec,
                                                 input logic [63:0] cause);
      logic [63:0] base;
      base = mtvec & ~64'h3;
      if (mtvec[1:0] == 2'b01 && cause[63])
         vector_target = base + ((cause & 64'h3F) << 2);
      else
         vector_target = base;
   endfunction

endpackage

// File: rtl/trap_sequencer.sv
// ---------------------------------------------------------------------------
// trap_sequencer -- walks the machine-mode CSR updates for a trap entry or an
// mret, one CSR write per cycle, then issues a one-cycle fetch redirect.
//
// Ports:
//   clk, reset                    clock, synchronous active-low reset
//   trap_valid/pc/cause/tval      trap request and its payload
//   mret_valid, mret_pc           mret request and the mret's own PC
//   req_ready                     high only in IDLE (and out of reset)
//   csr_raddr, csr_rdata          CSR read port (rdata combinational)
//   csr_we, csr_waddr, csr_wdata  CSR write port, one write per cycle
//   redirect_valid, redirect_pc   one-cycle fetch redirect
//   priv_mode                     current privilege level (3 = M, 0 = U)
//   dbg_state                     current sequencer state, for observation
//
// Handshake: a request is accepted on a cycle where req_ready and the
// request's valid are both high. While req_ready is low requests are
// ignored, not queued; the requester keeps valid high until accepted.
// trap_valid wins when both valids are high in the same cycle.
// ---------------------------------------------------------------------------
module trap_sequencer
   import common::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        trap_valid,
   input  logic [63:0] trap_pc,
   input  logic [63:0] trap_cause,
   input  logic [63:0] trap_tval,
   input  logic        mret_valid,
   input  logic [63:0] mret_pc,
   output logic        req_ready,
   output logic [11:0] csr_raddr,
   input  logic [63:0] csr_rdata,
   output logic        csr_we,
   output logic [11:0] csr_waddr,
   output logic [63:0] csr_wdata,
   output logic        redirect_valid,
   output logic [63:0] redirect_pc,
   output logic [1:0]  priv_mode,
   output state_e      dbg_state
);

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] cause_q, cause_d;
   logic [63:0] tval_q, tval_d;
   logic [1:0]  priv_q, priv_d;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cause_q <= '0;
         tval_q  <= '0;
         priv_q  <= PRIV_M;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cause_q <= cause_d;
         tval_q  <= tval_d;
         priv_q  <= priv_d;
      end
   end

   // Next-state and latched-payload logic
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cause_d = cause_q;
      tval_d  = tval_q;
      priv_d  = priv_q;
      case (state_q)
         IDLE: begin
            if (trap_valid) begin
               pc_d    = trap_pc;
               cause_d = trap_cause;
               tval_d  = trap_tval;
               state_d = T_EPC;
            end else if (mret_valid) begin
               if (priv_q == PRIV_M) begin
                  state_d = R_STATUS;
               end else begin
                  // mret outside M-mode becomes an illegal-instruction trap
                  pc_d    = mret_pc;
                  cause_d = CAUSE_ILLEGAL_INSN;
                  tval_d  = '0;
                  state_d = T_EPC;
               end
            end
         end
         T_EPC:    state_d = T_CAUSE;
         T_CAUSE:  state_d = T_TVAL;
         T_TVAL:   state_d = T_STATUS;
         T_STATUS: begin
            priv_d  = PRIV_M;
            state_d = T_REDIR;
         end
         T_REDIR:  state_d = IDLE;
         R_STATUS: begin
            // Return to the privilege saved in mstatus.MPP before it is cleared
            priv_d  = csr_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
            state_d = R_REDIR;
         end
         R_REDIR:  state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // Output logic: everything is decoded from the current state, so the
   // write bus and redirect are quiet whenever the block sits in IDLE.
   always_comb begin
      csr_raddr      = '0;
      csr_we         = 1'b0;
      csr_waddr      = '0;
      csr_wdata      = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state_q)
         T_EPC: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MEPC;
            csr_wdata = pc_q & ~64'h3;
         end
         T_CAUSE: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MCAUSE;
            csr_wdata = cause_q;
         end
         T_TVAL: begin
            csr_we    = 1'b1;
            csr_waddr = CSR_MTVAL;
            csr_wdata = tval_q;
         end
         T_STATUS: begin
            csr_raddr = CSR_MSTATUS;
            csr_we    = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = csr_rdata;
            csr_wdata[MSTATUS_MPIE] = csr_rdata[MSTATUS_MIE];
            csr_wdata[MSTATUS_MIE]  = 1'b0;
            csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_q;
         end
         T_REDIR: begin
            csr_raddr      = CSR_MTVEC;
            redirect_valid = 1'b1;
            redirect_pc    = vector_target(csr_rdata, cause_q);
         end
         R_STATUS: begin
            csr_raddr = CSR_MSTATUS;
            csr_we    = 1'b1;
            csr_waddr = CSR_MSTATUS;
            csr_wdata = csr_rdata;
            csr_wdata[MSTATUS_MIE]  = csr_rdata[MSTATUS_MPIE];
            csr_wdata[MSTATUS_MPIE] = 1'b1;
            csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
         end
         R_REDIR: begin
            csr_raddr      = CSR_MEPC;
            redirect_valid = 1'b1;
            redirect_pc    = csr_rdata & ~64'h3;
         end
         default: ;
      endcase
   end

   // Not ready while reset is held, even though the state is already IDLE
   assign req_ready = (state_q == IDLE) && reset;
   assign priv_mode = priv_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// ---------------------------------------------------------------------------
// tb_trap_sequencer -- self-checking bench for trap_sequencer.
// A small CSR file model answers reads and absorbs writes; a behavioural
// reference model predicts the write list, redirect target/latency and
// privilege for every accepted request.
// ---------------------------------------------------------------------------
module tb_trap_sequencer;
   import common::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        trap_valid;
   logic [63:0] trap_pc, trap_cause, trap_tval;
   logic        mret_valid;
   logic [63:0] mret_pc;
   logic        req_ready;
   logic [11:0] csr_raddr;
   logic [63:0] csr_rdata;
   logic        csr_we;
   logic [11:0] csr_waddr;
   logic [63:0] csr_wdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic [1:0]  priv_mode;
   state_e      dbg_state;

   trap_sequencer dut (
      .clk            (clk),
      .reset          (reset),
      .trap_valid     (trap_valid),
      .trap_pc        (trap_pc),
      .trap_cause     (trap_cause),
      .trap_tval      (trap_tval),
      .mret_valid     (mret_valid),
      .mret_pc        (mret_pc),
      .req_ready      (req_ready),
      .csr_raddr      (csr_raddr),
      .csr_rdata      (csr_rdata),
      .csr_we         (csr_we),
      .csr_waddr      (csr_waddr),
      .csr_wdata      (csr_wdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .priv_mode      (priv_mode),
      .dbg_state      (dbg_state)
   );

   // ---------------- CSR file environment ----------------
   logic [63:0] env_mstatus, env_mtvec, env_mepc, env_mcause, env_mtval;
   logic        ld_en = 1'b0;
   logic [63:0] ld_mstatus, ld_mtvec, ld_mepc;

   always @(posedge clk) begin
      if (ld_en) begin
         env_mstatus <= ld_mstatus;
         env_mtvec   <= ld_mtvec;
         env_mepc    <= ld_mepc;
      end else if (csr_we) begin
         case (csr_waddr)
            12'h300: env_mstatus <= csr_wdata;
            12'h305: env_mtvec   <= csr_wdata;
            12'h341: env_mepc    <= csr_wdata;
            12'h342: env_mcause  <= csr_wdata;
            12'h343: env_mtval   <= csr_wdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      case (csr_raddr)
         12'h300: csr_rdata = env_mstatus;
         12'h305: csr_rdata = env_mtvec;
         12'h341: csr_rdata = env_mepc;
         12'h342: csr_rdata = env_mcause;
         12'h343: csr_rdata = env_mtval;
         default: csr_rdata = 64'd0;
      endcase
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;

   logic [63:0] exp_q[$];
   logic [11:0] exp_addr_q[$];
   int          exp_cyc_q[$];
   logic [63:0] exp_rpc;
   int          exp_rcyc;
   logic [63:0] last_rpc;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [1:0]  mdl_priv;
   logic [63:0] mdl_mstatus, mdl_mtvec, mdl_mepc;

   function automatic logic [63:0] mdl_bit(input logic b, input int pos);
      return b ? (64'd1 << pos) : 64'd0;
   endfunction

   task automatic push_wr(input logic [11:0] a, input logic [63:0] d, input int c);
      exp_addr_q.push_back(a);
      exp_q.push_back(d);
      exp_cyc_q.push_back(c);
   endtask

   task automatic model_trap(input logic [63:0] pc, input logic [63:0] cause,
                             input logic [63:0] tval);
      logic [63:0] ms, tgt;
      ms = mdl_mstatus;
      ms = (ms & ~64'h1888) | mdl_bit(mdl_mstatus[3], 7) | (64'(mdl_priv) << 11);
      push_wr(12'h341, pc & ~64'h3, 1);
      push_wr(12'h342, cause, 2);
      push_wr(12'h343, tval, 3);
      push_wr(12'h300, ms, 4);
      mdl_mepc    = pc & ~64'h3;
      mdl_mstatus = ms;
      mdl_priv    = 2'd3;
      tgt = mdl_mtvec & ~64'h3;
      if ((mdl_mtvec % 4) == 1 && cause[63]) tgt = tgt + 4 * (cause % 64);
      exp_rpc  = tgt;
      exp_rcyc = 5;
   endtask

   task automatic model_mret(input logic [63:0] mpc);
      logic [63:0] ms;
      if (mdl_priv == 2'd3) begin
         ms = (mdl_mstatus & ~64'h1888) | mdl_bit(mdl_mstatus[7], 3) | 64'h80;
         push_wr(12'h300, ms, 1);
         mdl_priv    = mdl_mstatus[12:11];
         mdl_mstatus = ms;
         exp_rpc     = mdl_mepc & ~64'h3;
         exp_rcyc    = 2;
      end else begin
         model_trap(mpc, 64'd2, 64'd0);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_csr(input logic [63:0] ms, input logic [63:0] tv, input logic [63:0] ep);
      ld_mstatus = ms; ld_mtvec = tv; ld_mepc = ep; ld_en = 1'b1;
      mdl_mstatus = ms; mdl_mtvec = tv; mdl_mepc = ep;
      @(posedge clk);
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   // Observes cycles T+1.. after the accept edge; bounded at 8 cycles.
   task automatic observe(input bit keep_mret, output logic [63:0] rpc);
      bit seen;
      seen = 1'b0;
      rpc  = '0;
      for (int k = 1; k <= 8 && !seen; k++) begin
         @(negedge clk);
         trap_valid = 1'b0;
         if (!keep_mret) mret_valid = 1'b0;
         if (csr_we) begin
            if (exp_q.size() == 0) begin
               chk("wr_unexpected", 64'(csr_waddr), 64'd0);
            end else begin
               chk("wr_addr", 64'(csr_waddr), 64'(exp_addr_q.pop_front()));
               chk("wr_data", csr_wdata, exp_q.pop_front());
               chk("wr_cycle", 64'(k), 64'(exp_cyc_q.pop_front()));
            end
         end else begin
            chk("wbus_quiet", 64'(csr_waddr) | csr_wdata, 64'd0);
         end
         if (redirect_valid) begin
            seen = 1'b1;
            rpc  = redirect_pc;
            chk("redir_pc", redirect_pc, exp_rpc);
            chk("redir_cycle", 64'(k), 64'(exp_rcyc));
         end
         chk("busy_ready", 64'(req_ready), 64'd0);
      end
      chk("redir_seen", 64'(seen), 64'd1);
      chk("writes_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete(); exp_addr_q.delete(); exp_cyc_q.delete();
   endtask

   task automatic post_check();
      @(negedge clk);
      chk("post_ready", 64'(req_ready), 64'd1);
      chk("post_priv", 64'(priv_mode), 64'(mdl_priv));
      chk("post_state", 64'(dbg_state), 64'(IDLE));
   endtask

   // Called at a negedge while the DUT is idle.
   task automatic issue(input bit tv, input bit mv, input logic [63:0] pc,
                        input logic [63:0] cause, input logic [63:0] tval,
                        input logic [63:0] mpc);
      logic [63:0] r;
      chk("issue_ready", 64'(req_ready), 64'd1);
      trap_valid = tv; mret_valid = mv;
      trap_pc = pc; trap_cause = cause; trap_tval = tval; mret_pc = mpc;
      if (tv) model_trap(pc, cause, tval);
      else    model_mret(mpc);
      @(posedge clk);
      observe(tv && mv, r);
      last_rpc = r;
      post_check();
      if (tv && mv) begin
         // mret was held through the trap and is accepted right after redirect
         model_mret(mpc);
         @(posedge clk);
         observe(1'b0, r);
         last_rpc = r;
         post_check();
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset = 1'b0; trap_valid = 1'b0; mret_valid = 1'b0;
      trap_pc = '0; trap_cause = '0; trap_tval = '0; mret_pc = '0;
      ld_mstatus = '0; ld_mtvec = '0; ld_mepc = '0;
      env_mcause = '0; env_mtval = '0;
      mdl_priv = 2'd3; mdl_mstatus = '0; mdl_mtvec = '0; mdl_mepc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(req_ready), 64'd0);
      chk("rst_state", 64'(dbg_state), 64'(IDLE));
      chk("rst_priv", 64'(priv_mode), 64'd3);
      chk("rst_redir", 64'(redirect_valid), 64'd0);
      chk("rst_redir_pc", redirect_pc, 64'd0);
      chk("rst_we", 64'(csr_we), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Trap from M-mode
      load_csr(64'h8, 64'h8000_0000, 64'd0);
      issue(1'b1, 1'b0, 64'h1006, 64'd5, 64'hDEAD, 64'd0);
      chk("d1_mepc", env_mepc, 64'h1004);
      chk("d1_mcause", env_mcause, 64'd5);
      chk("d1_mtval", env_mtval, 64'hDEAD);
      chk("d1_mstatus", env_mstatus, 64'h1880);
      chk("d1_redir", last_rpc, 64'h8000_0000);

      // Vectored interrupt
      load_csr(64'h0, 64'h8000_0001, 64'd0);
      issue(1'b1, 1'b0, 64'h5000, 64'h8000_0000_0000_0007, 64'd0, 64'd0);
      chk("d2_redir", last_rpc, 64'h8000_001C);

      // mret in M-mode back to U
      load_csr(64'h80, 64'h8000_0000, 64'h2000);
      issue(1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 64'h9999);
      chk("d3_mstatus", env_mstatus, 64'h88);
      chk("d3_priv", 64'(priv_mode), 64'd0);
      chk("d3_redir", last_rpc, 64'h2000);

      // mret in U-mode traps as illegal instruction
      issue(1'b0, 1'b1, 64'd0, 64'd0, 64'd0, 64'h3000);
      chk("d4_mcause", env_mcause, 64'd2);
      chk("d4_mepc", env_mepc, 64'h3000);
      chk("d4_mtval", env_mtval, 64'd0);
      chk("d4_priv", 64'(priv_mode), 64'd3);

      // trap and mret together
      issue(1'b1, 1'b1, 64'h4000, 64'd11, 64'h77, 64'h4100);

      // Reset at T+2 of a trap
      load_csr(64'h8, 64'h8000_0000, 64'd0);
      trap_valid = 1'b1; trap_pc = 64'h6000; trap_cause = 64'd4; trap_tval = 64'h1;
      @(posedge clk);
      @(negedge clk);
      trap_valid = 1'b0;
      chk("ra_t1_we", 64'(csr_we), 64'd1);
      @(negedge clk);
      chk("ra_t2_we", 64'(csr_we), 64'd1);
      reset = 1'b0;
      for (int k = 3; k <= 8; k++) begin
         @(negedge clk);
         chk("ra_no_we", 64'(csr_we), 64'd0);
         chk("ra_no_redir", 64'(redirect_valid), 64'd0);
         if (k == 3) begin
            chk("ra_ready", 64'(req_ready), 64'd0);
            chk("ra_state", 64'(dbg_state), 64'(IDLE));
            chk("ra_priv", 64'(priv_mode), 64'd3);
         end
         if (k == 4) reset = 1'b1;
      end
      mdl_priv = 2'd3;

      // Randomized requests
      for (int i = 0; i < 60; i++) begin
         int kind;
         logic [63:0] tv, cause;
         if ($urandom_range(0, 3) == 0 || i == 0) begin
            tv = {$urandom, $urandom};
            tv[1:0] = 2'($urandom_range(0, 1));
            load_csr({$urandom, $urandom}, tv, {$urandom, $urandom});
         end
         kind  = $urandom_range(0, 9);
         cause = {$urandom, $urandom};
         if (kind < 5)
            issue(1'b1, 1'b0, {$urandom, $urandom}, cause, {$urandom, $urandom}, 64'd0);
         else if (kind < 9)
            issue(1'b0, 1'b1, 64'd0, 64'd0, 64'd0, {$urandom, $urandom});
         else
            issue(1'b1, 1'b1, {$urandom, $urandom}, cause, {$urandom, $urandom},
                  {$urandom, $urandom});
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
